execute: RTL and testbench

Execute stage of the LC-3 pipelined controller, directly downstream of the decode stage. On each enabled cycle it consumes decode's instruction register, next-PC and execute/writeback control words, plus the register-file read values. It registers an ALU result, a computed address, the destination register and branch-condition mask for the writeback, memory and controller stages. It also performs ALU-to-ALU forwarding from its own previous result.

---
 rtl/execute.sv | 155 +++++++++++++++
 tb/tb_execute.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute.sv
// LC-3 pipeline execute stage: ALU, address adder, destination/branch-mask
// decode and store-data capture, with ALU-to-ALU forwarding from aluout.
module execute (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_execute,
  input  logic [5:0]  E_Control,
  input  logic [1:0]  W_Control_in,
  input  logic [15:0] IR,
  input  logic [15:0] npc_in,
  input  logic [15:0] VSR1,
  input  logic [15:0] VSR2,
  input  logic        bypass_alu_1,
  input  logic        bypass_alu_2,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [15:0] aluout,
  output logic [15:0] pcout,
  output logic [1:0]  W_Control_out,
  output logic [2:0]  dr,
  output logic [2:0]  NZP,
  output logic [15:0] IR_Exec,
  output logic [15:0] M_Data
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [15:0] aluout_q, aluout_d;
  logic [15:0] pcout_q, pcout_d;
  logic [1:0]  wctl_q, wctl_d;
  logic [2:0]  dr_q, dr_d;
  logic [2:0]  nzp_q, nzp_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] mdata_q, mdata_d;

  logic [3:0]  opcode;
  logic [1:0]  alu_control;
  logic [1:0]  pcselect1;
  logic        pcselect2;
  logic        op2select;
  logic        is_store;
  logic [15:0] imm5, offset6, offset9, offset11;
  logic [15:0] op_a, op_b, op2, alu_res;
  logic [15:0] addend1, addend2;

  assign opcode      = IR[15:12];
  assign alu_control = E_Control[5:4];
  assign pcselect1   = E_Control[3:2];
  assign pcselect2   = E_Control[1];
  assign op2select   = E_Control[0];

  assign is_store = (opcode == OP_ST) || (opcode == OP_STR) || (opcode == OP_STI);

  // Register-file addresses go out combinationally so VSR1/VSR2 return this cycle.
  assign sr1 = IR[8:6];
  assign sr2 = is_store ? IR[11:9] : IR[2:0];

  assign imm5     = {{11{IR[4]}}, IR[4:0]};
  assign offset6  = {{10{IR[5]}}, IR[5:0]};
  assign offset9  = {{7{IR[8]}},  IR[8:0]};
  assign offset11 = {{5{IR[10]}}, IR[10:0]};

  assign op_a = bypass_alu_1 ? aluout_q : VSR1;
  assign op_b = bypass_alu_2 ? aluout_q : VSR2;
  assign op2  = op2select ? op_b : imm5;

  always_comb begin
    alu_res = 16'h0000;
    case (alu_control)
      2'b00:   alu_res = op_a + op2;
      2'b01:   alu_res = op_a & op2;
      2'b10:   alu_res = ~op_a;
      default: alu_res = 16'h0000;
    endcase
  end

  always_comb begin
    addend1 = 16'h0000;
    case (pcselect1)
      2'b00:   addend1 = offset11;
      2'b01:   addend1 = offset9;
      2'b10:   addend1 = offset6;
      default: addend1 = 16'h0000;
    endcase
  end

  assign addend2 = pcselect2 ? npc_in : op_a;

  always_comb begin
    aluout_d = aluout_q;
    pcout_d  = addend1 + addend2;
    wctl_d   = W_Control_in;
    ir_d     = IR;
    dr_d     = 3'b000;
    nzp_d    = 3'b000;
    mdata_d  = 16'h0000;

    // Non-ALU opcodes leave aluout alone so it remains a valid forwarding source.
    if (opcode == OP_ADD || opcode == OP_AND || opcode == OP_NOT)
      aluout_d = alu_res;

    case (opcode)
      OP_ADD, OP_AND, OP_NOT, OP_LEA, OP_LD, OP_LDR, OP_LDI: dr_d = IR[11:9];
      default: dr_d = 3'b000;
    endcase

    if (opcode == OP_BR)
      nzp_d = IR[11:9];
    else if (opcode == OP_JMP)
      nzp_d = 3'b111;

    if (is_store)
      mdata_d = op_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aluout_q <= 16'h0000;
      pcout_q  <= 16'h0000;
      wctl_q   <= 2'b00;
      dr_q     <= 3'b000;
      nzp_q    <= 3'b000;
      ir_q     <= 16'h0000;
      mdata_q  <= 16'h0000;
    end else if (enable_execute) begin
      aluout_q <= aluout_d;
      pcout_q  <= pcout_d;
      wctl_q   <= wctl_d;
      dr_q     <= dr_d;
      nzp_q    <= nzp_d;
      ir_q     <= ir_d;
      mdata_q  <= mdata_d;
    end
  end

  assign aluout        = aluout_q;
  assign pcout         = pcout_q;
  assign W_Control_out = wctl_q;
  assign dr            = dr_q;
  assign NZP           = nzp_q;
  assign IR_Exec       = ir_q;
  assign M_Data        = mdata_q;

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for the LC-3 execute stage: each vector pushes its
// hand-derived expected output bundle, which is popped after the clock edge.
module tb_execute;

  logic        clk;
  logic        rst;
  logic        enable_execute;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control_in;
  logic [15:0] IR;
  logic [15:0] npc_in;
  logic [15:0] VSR1;
  logic [15:0] VSR2;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [15:0] aluout;
  logic [15:0] pcout;
  logic [1:0]  W_Control_out;
  logic [2:0]  dr;
  logic [2:0]  NZP;
  logic [15:0] IR_Exec;
  logic [15:0] M_Data;

  int compared;
  int mismatched;

  typedef struct {
    logic        rst;
    logic        en;
    logic [5:0]  e;
    logic [1:0]  w;
    logic [15:0] ir;
    logic [15:0] npc;
    logic [15:0] v1;
    logic [15:0] v2;
    logic        b1;
    logic        b2;
    logic [71:0] exp;
  } vec_t;

  logic [71:0] exp_q[$];
  logic [71:0] obs;
  logic [71:0] expv;

  // {aluout, pcout, W_Control_out, dr, NZP, IR_Exec, M_Data}
  assign obs = {aluout, pcout, W_Control_out, dr, NZP, IR_Exec, M_Data};

  execute dut (
    .clk            (clk),
    .rst            (rst),
    .enable_execute (enable_execute),
    .E_Control      (E_Control),
    .W_Control_in   (W_Control_in),
    .IR             (IR),
    .npc_in         (npc_in),
    .VSR1           (VSR1),
    .VSR2           (VSR2),
    .bypass_alu_1   (bypass_alu_1),
    .bypass_alu_2   (bypass_alu_2),
    .sr1            (sr1),
    .sr2            (sr2),
    .aluout         (aluout),
    .pcout          (pcout),
    .W_Control_out  (W_Control_out),
    .dr             (dr),
    .NZP            (NZP),
    .IR_Exec        (IR_Exec),
    .M_Data         (M_Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r, input logic en, input logic [5:0] e, input logic [1:0] w,
    input logic [15:0] ir, input logic [15:0] npc, input logic [15:0] v1,
    input logic [15:0] v2, input logic b1, input logic b2,
    input logic [15:0] ealu, input logic [15:0] epc, input logic [1:0] ew,
    input logic [2:0] edr, input logic [2:0] enzp, input logic [15:0] eir,
    input logic [15:0] emd);
    vec_t v;
    v.rst = r;  v.en = en; v.e = e;   v.w = w;
    v.ir = ir;  v.npc = npc; v.v1 = v1; v.v2 = v2;
    v.b1 = b1;  v.b2 = b2;
    v.exp = {ealu, epc, ew, edr, enzp, eir, emd};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst            = v.rst;
    enable_execute = v.en;
    E_Control      = v.e;
    W_Control_in   = v.w;
    IR             = v.ir;
    npc_in         = v.npc;
    VSR1           = v.v1;
    VSR2           = v.v2;
    bypass_alu_1   = v.b1;
    bypass_alu_2   = v.b2;
    exp_q.push_back(v.exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t vs[$];
    vs.push_back(mk(1,1,6'b000001,2'b11,16'h1642,16'h3001,16'h0005,16'h0003,0,0,
                    16'h0000,16'h0000,2'b00,3'd0,3'b000,16'h0000,16'h0000));
    foreach (vs[i]) begin
      apply(vs[i]);
      tick();
      expv = exp_q.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("FAIL reset[%0d] got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_add_reg();
    vec_t vs[$];
    vs.push_back(mk(0,1,6'b000001,2'b00,16'h1642,16'h3001,16'h0005,16'h0003,0,0,
                    16'h0008,16'hFE47,2'b00,3'd3,3'b000,16'h1642,16'h0000));
    foreach (vs[i]) begin
      apply(vs[i]);
      #1;
      compared++;
      if ({sr1, sr2} !== {3'd1, 3'd2}) begin
        mismatched++;
        $display("FAIL add_reg_sr got sr1=%0d sr2=%0d expected sr1=1 sr2=2", sr1, sr2);
      end
      tick();
      expv = exp_q.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("FAIL add_reg[%0d] got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_add_imm();
    vec_t vs[$];
    vs.push_back(mk(0,1,6'b000000,2'b01,16'h14BF,16'h3001,16'h0000,16'h1234,0,0,
                    16'hFFFF,16'hFCBF,2'b01,3'd2,3'b000,16'h14BF,16'h0000));
    foreach (vs[i]) begin
      apply(vs[i]);
      tick();
      expv = exp_q.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("FAIL add_imm[%0d] got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_address();
    vec_t vs[$];
    vs.push_back(mk(0,1,6'b000110,2'b10,16'h29FE,16'h3001,16'h5555,16'h0000,0,0,
                    16'hFFFF,16'h2FFF,2'b10,3'd4,3'b000,16'h29FE,16'h0000));
    foreach (vs[i]) begin
      apply(vs[i]);
      tick();
      expv = exp_q.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("FAIL address[%0d] got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t vs[$];
    vs.push_back(mk(0,1,6'b000001,2'b00,16'h1642,16'h3001,16'h0008,16'h0008,0,0,
                    16'h0010,16'hFE4A,2'b00,3'd3,3'b000,16'h1642,16'h0000));
    vs.push_back(mk(0,1,6'b010001,2'b00,16'h5042,16'h3001,16'hFFFF,16'h00F0,1,0,
                    16'h0010,16'h0052,2'b00,3'd0,3'b000,16'h5042,16'h0000));
    vs.push_back(mk(0,1,6'b000001,2'b00,16'h1041,16'h3001,16'h7777,16'h7777,1,1,
                    16'h0020,16'h0051,2'b00,3'd0,3'b000,16'h1041,16'h0000));
    vs.push_back(mk(0,1,6'b100000,2'b00,16'h903F,16'h3001,16'h1234,16'h0000,1,0,
                    16'hFFDF,16'h005F,2'b00,3'd0,3'b000,16'h903F,16'h0000));
    vs.push_back(mk(0,1,6'b110001,2'b00,16'h1642,16'h3001,16'h0001,16'h0001,0,0,
                    16'h0000,16'hFE43,2'b00,3'd3,3'b000,16'h1642,16'h0000));
    foreach (vs[i]) begin
      apply(vs[i]);
      tick();
      expv = exp_q.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("FAIL back_to_back[%0d] got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_branch_hold();
    vec_t vs[$];
    vs.push_back(mk(0,1,6'b000000,2'b00,16'h14BF,16'h3001,16'h0002,16'h0000,0,0,
                    16'h0001,16'hFCC1,2'b00,3'd2,3'b000,16'h14BF,16'h0000));
    vs.push_back(mk(0,1,6'b000110,2'b11,16'h0C05,16'h3010,16'h0000,16'h0000,0,0,
                    16'h0001,16'h3015,2'b11,3'd0,3'b110,16'h0C05,16'h0000));
    for (int k = 0; k < 3; k++)
      vs.push_back(mk(0,0,6'b000001,2'b01,16'h7281,16'hAAAA,16'h5555,16'h6666,1,1,
                      16'h0001,16'h3015,2'b11,3'd0,3'b110,16'h0C05,16'h0000));
    vs.push_back(mk(0,1,6'b000110,2'b00,16'h0005,16'h3010,16'h0000,16'h0000,0,0,
                    16'h0001,16'h3015,2'b00,3'd0,3'b000,16'h0005,16'h0000));
    vs.push_back(mk(0,1,6'b001100,2'b00,16'hC1C0,16'h3010,16'h4000,16'h0000,0,0,
                    16'h0001,16'h4000,2'b00,3'd0,3'b111,16'hC1C0,16'h0000));
    foreach (vs[i]) begin
      apply(vs[i]);
      tick();
      expv = exp_q.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("FAIL branch_hold[%0d] got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_reset_midstream();
    vec_t vs[$];
    vs.push_back(mk(1,1,6'b000001,2'b01,16'h1642,16'h3001,16'h0005,16'h0003,0,0,
                    16'h0000,16'h0000,2'b00,3'd0,3'b000,16'h0000,16'h0000));
    vs.push_back(mk(0,1,6'b001001,2'b00,16'h7281,16'h3001,16'h1000,16'hBEEF,0,0,
                    16'h0000,16'h1001,2'b00,3'd0,3'b000,16'h7281,16'hBEEF));
    vs.push_back(mk(0,1,6'b000001,2'b00,16'h1642,16'h3001,16'h9999,16'h0003,1,0,
                    16'h0003,16'hFE42,2'b00,3'd3,3'b000,16'h1642,16'h0000));
    foreach (vs[i]) begin
      apply(vs[i]);
      if (i == 1) begin
        #1;
        compared++;
        if ({sr1, sr2} !== {3'd2, 3'd1}) begin
          mismatched++;
          $display("FAIL str_sr got sr1=%0d sr2=%0d expected sr1=2 sr2=1", sr1, sr2);
        end
      end
      tick();
      expv = exp_q.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("FAIL reset_midstream[%0d] got %h expected %h", i, obs, expv);
      end
    end
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    rst            = 1'b1;
    enable_execute = 1'b0;
    E_Control      = 6'b000000;
    W_Control_in   = 2'b00;
    IR             = 16'h0000;
    npc_in         = 16'h0000;
    VSR1           = 16'h0000;
    VSR2           = 16'h0000;
    bypass_alu_1   = 1'b0;
    bypass_alu_2   = 1'b0;
    tick();

    test_reset();
    test_add_reg();
    test_add_imm();
    test_address();
    test_back_to_back();
    test_branch_hold();
    test_reset_midstream();

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
